// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one iterative fp_div/fp_rnd pair between two requesters.
// Optional performance counters are enabled with `define FP_DIV_ARB_PERF_EN.

package fp_div_arbiter_pkg;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  function automatic int fp_width(fp_format_e fmt);
    case (fmt)
      FP64:       return 64;
      FP16, BF16: return 16;
      default:    return 32;
    endcase
  endfunction
endpackage

module fp_div_arbiter
  import fp_div_arbiter_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  parameter int         NREQ      = 2,
  localparam int        FP_WIDTH  = fp_width(FP_FORMAT)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*FP_WIDTH-1:0] req_a_i,
  input  logic [NREQ*FP_WIDTH-1:0] req_b_i,
  input  logic [NREQ*3-1:0]        req_rnd_i,
  output logic                     div_start_o,
  output logic [FP_WIDTH-1:0]      div_a_o,
  output logic [FP_WIDTH-1:0]      div_b_o,
  output logic [2:0]               div_rnd_o,
  input  logic                     div_done_i,
  input  logic [FP_WIDTH-1:0]      div_result_i,
  input  logic [4:0]               div_flags_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_id_o,
  output logic [FP_WIDTH-1:0]      rsp_result_o,
  output logic [4:0]               rsp_flags_o
`ifdef FP_DIV_ARB_PERF_EN
  ,
  output logic [31:0]              perf_done0_o,
  output logic [31:0]              perf_done1_o,
  output logic [31:0]              perf_busy_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              r_state;
  state_e              w_next_state;
  logic                r_last_grant;
  logic                r_id;
  logic [FP_WIDTH-1:0] r_a;
  logic [FP_WIDTH-1:0] r_b;
  logic [2:0]          r_rnd;
  logic [FP_WIDTH-1:0] r_rsp_result;
  logic [4:0]          r_rsp_flags;
  logic [NREQ-1:0]     w_grant;
  logic                w_grant_id;
  logic                w_accept;
  logic                w_rsp_fire;
  logic [FP_WIDTH-1:0] w_sel_a;
  logic [FP_WIDTH-1:0] w_sel_b;
  logic [2:0]          w_sel_rnd;

  // Grants only in IDLE; on contention the requester not served last wins.
  always_comb begin
    w_grant = '0;
    if (r_state == S_IDLE && !reset_i) begin
      case (req_valid_i)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_grant_id  = w_grant[1];
  assign w_accept    = |w_grant;
  assign req_ready_o = w_grant;
  assign w_sel_a     = w_grant_id ? req_a_i[FP_WIDTH +: FP_WIDTH] : req_a_i[0 +: FP_WIDTH];
  assign w_sel_b     = w_grant_id ? req_b_i[FP_WIDTH +: FP_WIDTH] : req_b_i[0 +: FP_WIDTH];
  assign w_sel_rnd   = w_grant_id ? req_rnd_i[3 +: 3] : req_rnd_i[0 +: 3];
  assign w_rsp_fire  = (r_state == S_RESP) && rsp_ready_i;

  always_comb begin
    w_next_state = r_state;
    div_start_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_START;
      end
      S_START: begin
        div_start_o  = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (div_done_i) w_next_state = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operands and id stay untouched until the next accept, which keeps them stable through WAIT.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_rnd        <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_rnd        <= w_sel_rnd;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == S_WAIT && div_done_i) begin
        r_rsp_result <= div_result_i;
        r_rsp_flags  <= div_flags_i;
      end
    end
  end

  assign div_a_o      = r_a;
  assign div_b_o      = r_b;
  assign div_rnd_o    = r_rnd;
  assign rsp_id_o     = r_id;
  assign rsp_result_o = r_rsp_result;
  assign rsp_flags_o  = r_rsp_flags;

`ifdef FP_DIV_ARB_PERF_EN
  logic [31:0] r_perf_done0;
  logic [31:0] r_perf_done1;
  logic [31:0] r_perf_busy;

  // Done counters wrap; the busy counter saturates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perf_done0 <= '0;
      r_perf_done1 <= '0;
      r_perf_busy  <= '0;
    end else begin
      if (w_rsp_fire && !r_id) r_perf_done0 <= r_perf_done0 + 32'd1;
      if (w_rsp_fire && r_id)  r_perf_done1 <= r_perf_done1 + 32'd1;
      if (r_state != S_IDLE && r_perf_busy != 32'hFFFF_FFFF) r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_done0_o = r_perf_done0;
  assign perf_done1_o = r_perf_done1;
  assign perf_busy_o  = r_perf_busy;
`else
  logic w_unused_fire;
  assign w_unused_fire = w_rsp_fire;
`endif

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed self-checking bench for fp_div_arbiter; the bench drives div_done itself,
// acting as the fp_div/fp_rnd model with hand-chosen latency and results.

module tb_fp_div_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [63:0] reqA;
  logic [63:0] reqB;
  logic [5:0]  reqRnd;
  logic        divStart;
  logic [31:0] divA;
  logic [31:0] divB;
  logic [2:0]  divRnd;
  logic        divDone;
  logic [31:0] divResult;
  logic [4:0]  divFlags;
  logic        rspValid;
  logic        rspReady;
  logic        rspId;
  logic [31:0] rspResult;
  logic [4:0]  rspFlags;
`ifdef FP_DIV_ARB_PERF_EN
  logic [31:0] perfDone0;
  logic [31:0] perfDone1;
  logic [31:0] perfBusy;
`endif

  int nAsserts = 0;
  int nFail    = 0;

  fp_div_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_a_i      (reqA),
    .req_b_i      (reqB),
    .req_rnd_i    (reqRnd),
    .div_start_o  (divStart),
    .div_a_o      (divA),
    .div_b_o      (divB),
    .div_rnd_o    (divRnd),
    .div_done_i   (divDone),
    .div_result_i (divResult),
    .div_flags_i  (divFlags),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_id_o     (rspId),
    .rsp_result_o (rspResult),
    .rsp_flags_o  (rspFlags)
`ifdef FP_DIV_ARB_PERF_EN
    ,
    .perf_done0_o (perfDone0),
    .perf_done1_o (perfDone1),
    .perf_busy_o  (perfBusy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where the start pulse is visible; done is seen by the DUT lat cycles after start.
  task automatic applyStimulus(input int lat, input logic [31:0] expA, input logic [31:0] res,
                               input logic [4:0] flg);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      checkOutput("wait_start_low", 32'(divStart), 32'h0);
      checkOutput("wait_rsp_low", 32'(rspValid), 32'h0);
      checkOutput("wait_a_hold", divA, expA);
    end
    divDone   = 1'b1;
    divResult = res;
    divFlags  = flg;
    @(negedge clk);
    divDone   = 1'b0;
    divResult = 32'hBAD0_BAD0;
    divFlags  = 5'h1F;
    #1;
    checkOutput("rsp_valid_up", 32'(rspValid), 32'h1);
  endtask

  task automatic retire();
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    #1;
    checkOutput("rsp_retired", 32'(rspValid), 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    reqValid  = 2'b00;
    reqA      = '0;
    reqB      = '0;
    reqRnd    = '0;
    divDone   = 1'b0;
    divResult = '0;
    divFlags  = '0;
    rspReady  = 1'b0;

    // Reset values, including ready held low while a request is already valid
    repeat (2) @(negedge clk);
    reqValid = 2'b01;
    #1;
    checkOutput("rst_req_ready", 32'(reqReady), 32'h0);
    checkOutput("rst_div_start", 32'(divStart), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("rst_div_a", divA, 32'h0);
    checkOutput("rst_rsp_result", rspResult, 32'h0);
    checkOutput("rst_rsp_id", 32'(rspId), 32'h0);
    reqValid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Spurious done in IDLE
    divDone   = 1'b1;
    divResult = 32'hDEAD_BEEF;
    divFlags  = 5'h1F;
    @(negedge clk);
    divDone = 1'b0;
    @(negedge clk);
    checkOutput("spur_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("spur_div_start", 32'(divStart), 32'h0);
    checkOutput("spur_rsp_result", rspResult, 32'h0);

    // Single request from requester 0: 1.0 / 2.0
    reqA     = {32'h0, 32'h3F80_0000};
    reqB     = {32'h0, 32'h4000_0000};
    reqRnd   = 6'b000_000;
    reqValid = 2'b01;
    #1;
    checkOutput("single_ready", 32'(reqReady), 32'h1);
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    checkOutput("single_start", 32'(divStart), 32'h1);
    checkOutput("single_div_a", divA, 32'h3F80_0000);
    checkOutput("single_div_b", divB, 32'h4000_0000);
    checkOutput("single_div_rnd", 32'(divRnd), 32'h0);
    checkOutput("single_busy_ready", 32'(reqReady), 32'h0);
    applyStimulus(10, 32'h3F80_0000, 32'h3F00_0000, 5'b00000);
    checkOutput("single_rsp_id", 32'(rspId), 32'h0);
    checkOutput("single_rsp_result", rspResult, 32'h3F00_0000);
    checkOutput("single_rsp_flags", 32'(rspFlags), 32'h0);
    retire();

    // Contention from reset: grants alternate 0,1,0,1
    doReset();
    reqA     = {32'h2222_2222, 32'h1111_1111};
    reqB     = {32'h4444_4444, 32'h3333_3333};
    reqRnd   = {3'd2, 3'd1};
    reqValid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      logic expId;
      expId = j[0];
      #1;
      checkOutput("cont_ready", 32'(reqReady), expId ? 32'h2 : 32'h1);
      @(negedge clk);
      #1;
      checkOutput("cont_start", 32'(divStart), 32'h1);
      checkOutput("cont_div_a", divA, expId ? 32'h2222_2222 : 32'h1111_1111);
      checkOutput("cont_div_rnd", 32'(divRnd), expId ? 32'h2 : 32'h1);
      applyStimulus(3, expId ? 32'h2222_2222 : 32'h1111_1111, 32'hA000_0000 + 32'(j), 5'b00000);
      checkOutput("cont_rsp_id", 32'(rspId), 32'(expId));
      checkOutput("cont_rsp_result", rspResult, 32'hA000_0000 + 32'(j));
      checkOutput("cont_no_accept", 32'(reqReady), 32'h0);
      retire();
    end

    // Backpressure: response held for 20 cycles while both requesters wait
    reqValid = 2'b01;
    #1;
    checkOutput("bp_ready", 32'(reqReady), 32'h1);
    @(negedge clk);
    reqValid = 2'b11;
    #1;
    checkOutput("bp_start", 32'(divStart), 32'h1);
    applyStimulus(4, 32'h1111_1111, 32'h5A5A_5A5A, 5'b00001);
    repeat (20) begin
      @(negedge clk);
      #1;
      checkOutput("bp_rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("bp_rsp_result", rspResult, 32'h5A5A_5A5A);
      checkOutput("bp_rsp_flags", 32'(rspFlags), 32'h01);
      checkOutput("bp_rsp_id", 32'(rspId), 32'h0);
      checkOutput("bp_req_ready", 32'(reqReady), 32'h0);
    end
    reqA = {32'h3F80_0000, 32'h1111_1111};
    reqB = {32'h0000_0000, 32'h3333_3333};
    retire();
    checkOutput("bp_resume_ready", 32'(reqReady), 32'h2);

    // Divide by zero from requester 1
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    checkOutput("dz_start", 32'(divStart), 32'h1);
    checkOutput("dz_div_a", divA, 32'h3F80_0000);
    checkOutput("dz_div_b", divB, 32'h0);
    applyStimulus(6, 32'h3F80_0000, 32'h7F80_0000, 5'b01000);
    checkOutput("dz_rsp_id", 32'(rspId), 32'h1);
    checkOutput("dz_rsp_result", rspResult, 32'h7F80_0000);
    checkOutput("dz_rsp_flags", 32'(rspFlags), 32'h08);
    retire();

    // Async reset during WAIT of a job from requester 0
    reqValid = 2'b01;
    #1;
    checkOutput("ar_ready", 32'(reqReady), 32'h1);
    @(negedge clk);
    reqValid = 2'b11;
    #1;
    checkOutput("ar_start", 32'(divStart), 32'h1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("ar_div_start", 32'(divStart), 32'h0);
    checkOutput("ar_req_ready", 32'(reqReady), 32'h0);
    checkOutput("ar_div_a", divA, 32'h0);
    reqValid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    divDone   = 1'b1;
    divResult = 32'h1234_5678;
    @(negedge clk);
    divDone = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("ar_no_stale_rsp", 32'(rspValid), 32'h0);
    end
    reqValid = 2'b11;
    #1;
    checkOutput("ar_first_grant", 32'(reqReady), 32'h1);
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    checkOutput("ar_new_start", 32'(divStart), 32'h1);
    checkOutput("ar_new_div_a", divA, 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
